// File: rtl/syn_pipe_ctl_pkg.sv
// Shared pipeline-control definitions: datapath mux selects, field widths, FSM encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package syn_pipe_ctl_pkg;

   // Datapath widths
   localparam int REG_BIT   = 5;
   localparam int STATE_BIT = 2;

   // PC source mux selects used by the fetch stage
   localparam logic [1:0] MUX_PC_SEQ = 2'd0;
   localparam logic [1:0] MUX_PC_BR  = 2'd1;
   localparam logic [1:0] MUX_PC_JR  = 2'd2;

   // Cycles from halt detection in EX until the halting instruction leaves WB
   localparam int PIPE_CTL_DRAIN_DEFAULT = 3;

   typedef enum logic [STATE_BIT-1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } pipe_state_e;

endpackage

// File: rtl/syn_pipe_ctl_hazard.sv
// Load-use hazard detector: ID source register matches a pending load destination in EX.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result feeds the stall logic in syn_pipe_ctl.
// Ports: id_rs/id_rt + use flags (ID operands), ex_load/ex_w_en/ex_req_w (EX writer), load_use (out).
module cmb_hazard_detect
   import syn_pipe_ctl_pkg::*;
(
   input  logic [REG_BIT-1:0] id_rs,
   input  logic [REG_BIT-1:0] id_rt,
   input  logic               id_use_rs,
   input  logic               id_use_rt,
   input  logic               ex_load,
   input  logic               ex_w_en,
   input  logic [REG_BIT-1:0] ex_req_w,
   output logic               load_use
);

   // r0 is hardwired to zero, so a load targeting it never creates a dependency
   assign load_use = ex_load && ex_w_en && (ex_req_w != '0) &&
                     ((id_use_rs && (id_rs == ex_req_w)) ||
                      (id_use_rt && (id_rt == ex_req_w)));

endmodule

// File: rtl/syn_pipe_ctl.sv
// Five-stage pipeline controller: stage enables, flush/stall bubbles, halt drain, single-step.
// Latency: enables/clears combinational from state+inputs; halted registered (1 cycle).
// Backpressure: en low or no step pulse freezes all state and drops every stage enable.
// Ports: clk, rst_n, en, step_mode, step, ID/EX hazard inputs, load_pc, halt_ex ->
//        per-stage enables, if_id_clr_n/id_ex_clr_n, halted, stall_cnt, flush_cnt.
// Build option: PIPE_CTL_PERF_CNT_EN enables the stall/flush counters (tied to 0 otherwise).
module syn_pipe_ctl
   import syn_pipe_ctl_pkg::*;
#(
   parameter int CNT_BIT   = 16,
   parameter int DRAIN_CYC = PIPE_CTL_DRAIN_DEFAULT
)
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               step_mode,
   input  logic               step,
   input  logic [4:0]         id_rs,
   input  logic [4:0]         id_rt,
   input  logic               id_use_rs,
   input  logic               id_use_rt,
   input  logic               ex_load,
   input  logic               ex_w_en,
   input  logic [4:0]         ex_req_w,
   input  logic               load_pc,
   input  logic               halt_ex,
   output logic               pc_en,
   output logic               if_id_en,
   output logic               id_ex_en,
   output logic               ex_dm_en,
   output logic               dm_wb_en,
   output logic               if_id_clr_n,
   output logic               id_ex_clr_n,
   output logic               halted,
   output logic [CNT_BIT-1:0] stall_cnt,
   output logic [CNT_BIT-1:0] flush_cnt
);

   localparam int DRAIN_BIT = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
   localparam logic [DRAIN_BIT-1:0] DRAIN_LOAD = DRAIN_BIT'(DRAIN_CYC - 1);

   pipe_state_e          state_q, state_d;
   logic [DRAIN_BIT-1:0] drain_cnt_q, drain_cnt_d;
   logic                 step_q, step_d;
   logic                 step_dly_q, step_dly_d;
   logic                 halted_q, halted_d;
   logic                 load_use;
   logic                 adv;
   logic                 do_stall;
   logic                 do_flush;

   cmb_hazard_detect u_hazard (
      .id_rs     (id_rs),
      .id_rt     (id_rt),
      .id_use_rs (id_use_rs),
      .id_use_rt (id_use_rt),
      .ex_load   (ex_load),
      .ex_w_en   (ex_w_en),
      .ex_req_w  (ex_req_w),
      .load_use  (load_use)
   );

   // step_q is a one-cycle pulse per rising edge of step, so a held step advances once
   assign adv = en && (!step_mode || step_q);

   always_comb begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      ex_dm_en    = 1'b0;
      dm_wb_en    = 1'b0;
      if_id_clr_n = 1'b1;
      id_ex_clr_n = 1'b1;
      do_stall    = 1'b0;
      do_flush    = 1'b0;
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      step_d      = en ? (step && !step_dly_q) : step_q;
      step_dly_d  = en ? step : step_dly_q;

      if (adv) begin
         case (state_q)
            ST_RUN: begin
               if (halt_ex) begin
                  // Freeze fetch/decode, let the halting instruction move on behind a bubble
                  id_ex_en    = 1'b1;
                  ex_dm_en    = 1'b1;
                  dm_wb_en    = 1'b1;
                  id_ex_clr_n = 1'b0;
                  state_d     = ST_DRAIN;
                  drain_cnt_d = DRAIN_LOAD;
               end else if (load_pc) begin
                  // Flush wins over load-use: the dependent instruction is squashed anyway
                  {pc_en, if_id_en, id_ex_en, ex_dm_en, dm_wb_en} = 5'b11111;
                  if_id_clr_n = 1'b0;
                  id_ex_clr_n = 1'b0;
                  do_flush    = 1'b1;
               end else if (load_use) begin
                  id_ex_en    = 1'b1;
                  ex_dm_en    = 1'b1;
                  dm_wb_en    = 1'b1;
                  id_ex_clr_n = 1'b0;
                  do_stall    = 1'b1;
               end else begin
                  {pc_en, if_id_en, id_ex_en, ex_dm_en, dm_wb_en} = 5'b11111;
               end
            end
            ST_DRAIN: begin
               id_ex_en    = 1'b1;
               ex_dm_en    = 1'b1;
               dm_wb_en    = 1'b1;
               id_ex_clr_n = 1'b0;
               if (drain_cnt_q == '0) begin
                  state_d = ST_HALTED;
               end else begin
                  drain_cnt_d = drain_cnt_q - 1'b1;
               end
            end
            ST_HALTED: begin
            end
            default: state_d = ST_RUN;
         endcase
      end

      halted_d = (state_d == ST_HALTED);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         drain_cnt_q <= '0;
         step_q      <= 1'b0;
         step_dly_q  <= 1'b0;
         halted_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
         step_q      <= step_d;
         step_dly_q  <= step_dly_d;
         halted_q    <= halted_d;
      end
   end

   assign halted = halted_q;

`ifdef PIPE_CTL_PERF_CNT_EN
   logic [CNT_BIT-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_BIT-1:0] flush_cnt_q, flush_cnt_d;

   // Saturating: a pegged counter means "at least this many", never a small wrapped value
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (do_stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
      if (do_flush && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   logic unused_perf;
   assign unused_perf = do_stall ^ do_flush;
   assign stall_cnt   = '0;
   assign flush_cnt   = '0;
`endif

endmodule
